regfile_wb_arbiter: RTL and testbench

Arbitrates the register file's single write port between two writeback sources: the ALU result path and the memory load path.

- Each source presents a valid/ready request carrying a destination register and data.
- The block grants one per cycle, round-robin on conflict, and drives a registered write (we3/ad3/wd3) into the register file one cycle later.
- It also exports a pending-write mask so decode can detect read-after-write hazards against the in-flight write.

---
 rtl/regfile_wb_arbiter_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_if.sv | 48 ++++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 71 +++++++
 tb/tb_regfile_wb_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg
// Shared types and constants for the register-file writeback arbiter.
//   D_WIDTH_DEF / A_WIDTH_DEF : default data and register-address widths
//   grant_t                   : which source won the most recent transfer
//   CNT_W                     : width of the contention counter
package regfile_pkg;

    localparam int D_WIDTH_DEF = 32;
    localparam int A_WIDTH_DEF = 5;
    localparam int CNT_W       = 16;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
// Bundles both writeback request channels, the register-file write port and
// the status outputs of the arbiter.
//   alu_valid/alu_ready/alu_addr/alu_data : ALU writeback request
//   mem_valid/mem_ready/mem_addr/mem_data : load writeback request
//   we3/ad3/wd3                           : registered register-file write
//   pend_mask                             : one-hot of the register in flight
//   conflict_cnt                          : saturating contention count
// Modports: master = requesters / observer, slave = arbiter.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
);

    logic                  alu_valid;
    logic                  alu_ready;
    logic [A_WIDTH-1:0]    alu_addr;
    logic [D_WIDTH-1:0]    alu_data;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [A_WIDTH-1:0]    mem_addr;
    logic [D_WIDTH-1:0]    mem_data;

    logic                  we3;
    logic [A_WIDTH-1:0]    ad3;
    logic [D_WIDTH-1:0]    wd3;

    logic [2**A_WIDTH-1:0] pend_mask;
    logic [CNT_W-1:0]      conflict_cnt;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready,
        input  we3, ad3, wd3, pend_mask, conflict_cnt
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready,
        output we3, ad3, wd3, pend_mask, conflict_cnt
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   req[0] = ALU request, req[1] = MEM request
//   last_grant = source that won the previous transfer
//   gnt = one-hot grant (same bit order as req), all-zero when idle
module rr_arb2
    import regfile_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // on conflict the source that did not win last time goes first
            2'b11:   gnt = (last_grant == GNT_MEM) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU result path
// and the memory load path. One request is granted per cycle (round-robin on
// conflict) and turned into a registered we3/ad3/wd3 write the next cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request channels, write port and status (slave side)
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
)(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    logic [1:0]         req;
    logic [1:0]         gnt;
    grant_t             last_grant;
    logic               xfer;
    logic [A_WIDTH-1:0] win_addr;
    logic [D_WIDTH-1:0] win_data;

    assign req = {bus.mem_valid, bus.alu_valid};

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    // readys are gated by rst_n so nothing is accepted while reset is held
    assign bus.alu_ready = rst_n & gnt[0];
    assign bus.mem_ready = rst_n & gnt[1];
    assign xfer          = bus.alu_ready | bus.mem_ready;

    assign win_addr = gnt[0] ? bus.alu_addr : bus.mem_addr;
    assign win_data = gnt[0] ? bus.alu_data : bus.mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant       <= GNT_MEM;
            bus.we3          <= 1'b0;
            bus.ad3          <= '0;
            bus.wd3          <= '0;
            bus.conflict_cnt <= '0;
        end else begin
            if (xfer) begin
                last_grant <= gnt[0] ? GNT_ALU : GNT_MEM;
                bus.ad3    <= win_addr;
                bus.wd3    <= win_data;
                // x0 is hardwired to zero: accept the request, drop the write
                bus.we3    <= (win_addr != '0);
            end else begin
                bus.we3    <= 1'b0;
            end

            if (bus.alu_valid && bus.mem_valid && (bus.conflict_cnt != '1))
                bus.conflict_cnt <= bus.conflict_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        bus.pend_mask = '0;
        if (bus.we3)
            bus.pend_mask[bus.ad3] = 1'b1;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   exp_cnt;
    wr_t  sb[$];

    regfile_wb_arbiter_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();

    regfile_wb_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expected one.
    always @(negedge clk) begin
        if (bus.we3 === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", 64'(bus.ad3), 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                logic [31:0] exp_mask;
                e = sb.pop_front();
                exp_mask = 32'd1 << e.addr;
                chk("write_cycle", 64'(cyc), 64'(e.cyc));
                chk("ad3", 64'(bus.ad3), 64'(e.addr));
                chk("wd3", 64'(bus.wd3), 64'(e.data));
                chk("pend_mask", 64'(bus.pend_mask), 64'(exp_mask));
            end
        end
    end

    // One cycle of stimulus with hand-computed expected readys.
    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input logic ear, input logic emr);
        wr_t e;
        @(posedge clk);
        #1;
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
        @(negedge clk);
        chk("alu_ready", 64'(bus.alu_ready), 64'(ear));
        chk("mem_ready", 64'(bus.mem_ready), 64'(emr));
        chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(exp_cnt));
        if (av && mv && exp_cnt != 32'hFFFF) exp_cnt++;
        if (ear && aa != 0) begin
            e.cyc = cyc + 1; e.addr = aa; e.data = ad;
            sb.push_back(e);
        end
        if (emr && ma != 0) begin
            e.cyc = cyc + 1; e.addr = ma; e.data = md;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Reset asserted just after a clock edge; with mid=1 the previous cycle
    // accepted ALU addr 7 and its write must vanish at once.
    task automatic do_reset(input logic mid);
        @(posedge clk);
        #1;
        if (mid) begin
            chk("mid_we3_before_reset", 64'(bus.we3), 64'd1);
            chk("mid_ad3_before_reset", 64'(bus.ad3), 64'd7);
        end
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd4;
        rst_n = 1'b0;
        #1;
        chk("rst_we3", 64'(bus.we3), 64'd0);
        chk("rst_pend_mask", 64'(bus.pend_mask), 64'd0);
        chk("rst_cnt", 64'(bus.conflict_cnt), 64'd0);
        chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_we3", 64'(bus.we3), 64'd0);
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 0;
        rst_n    = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEADBEEF;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd6; bus.mem_data = 32'h0;

        #3;
        chk("init_we3", 64'(bus.we3), 64'd0);
        chk("init_pend_mask", 64'(bus.pend_mask), 64'd0);
        chk("init_cnt", 64'(bus.conflict_cnt), 64'd0);
        chk("init_alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("init_mem_ready", 64'(bus.mem_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        rst_n = 1'b1;

        // first single ALU write
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1, 1'b0);
        idle();
        // MEM transfer leaves last_grant = MEM so ALU wins the next conflict
        step(1'b0, '0, '0, 1'b1, 5'd3, 32'h0000_0033, 1'b0, 1'b1);

        // continuous contention: ALU, MEM, ALU, MEM
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 1'b0);
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b1);
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 1'b0);
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b1);
        idle();
        chk("cnt_after_contention", 64'(bus.conflict_cnt), 64'd4);

        // write to x0 is accepted but suppressed
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1);
        idle();
        chk("x0_we3", 64'(bus.we3), 64'd0);
        chk("x0_pend_mask", 64'(bus.pend_mask), 64'd0);

        // MEM held while ALU takes its turn, then granted with the same data
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hCAFE, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 5'd10, 32'hCAFE, 1'b0, 1'b1);

        // back-to-back uncontested ALU
        step(1'b1, 5'd4, 32'h44, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 5'd31, 32'hFFFF_0001, 1'b0, '0, '0, 1'b1, 1'b0);

        // accepted ALU write to 7, killed by reset the next cycle (no push)
        @(posedge clk);
        #1;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h77;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        chk("mid_alu_ready", 64'(bus.alu_ready), 64'd1);
        do_reset(1'b1);

        // first conflict after reset goes to ALU
        step(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 5'd12, 32'hC, 1'b0, 1'b1);
        idle();
        idle();

        // saturation of the contention counter
        do_reset(1'b0);
        @(posedge clk);
        #1;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'h0;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd0; bus.mem_data = 32'h0;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("cnt_fffe", 64'(bus.conflict_cnt), 64'hFFFE);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("cnt_saturated", 64'(bus.conflict_cnt), 64'hFFFF);
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
